// File: rtl/hitmap_serializer.sv
// hitmap_serializer: captures a hit-map frame (header word plus ROWS row
// words) on the header strobe and streams it out one word per transfer
// over a valid/ready interface. Frames arriving while one is in flight are
// dropped and flagged on the sticky overflow output.
//
// Optional feature: define HITMAP_SERIALIZER_HITCOUNT_EN to append a trailer
// word carrying the fiber id and the number of set bits across all rows.
module hitmap_serializer #(
  parameter int ROWS  = 38,
  parameter int WIDTH = 38
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      hdr_in,
  input  logic [ROWS*WIDTH-1:0] rows_in,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overflow
);

  localparam int STROBE_BIT = 37;
  localparam int IDX_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

`ifdef HITMAP_SERIALIZER_HITCOUNT_EN
  // The trailer, not the last row, closes the frame.
  localparam logic ROW_ENDS_FRAME = 1'b0;
  localparam int   CNT_W          = 11;
`else
  localparam logic ROW_ENDS_FRAME = 1'b1;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
`ifdef HITMAP_SERIALIZER_HITCOUNT_EN
    S_ROWS = 2'd2,
    S_TRAIL = 2'd3
`else
    S_ROWS = 2'd2
`endif
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             busy_q;
  logic             overflow_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [WIDTH-1:0] row_q [ROWS];

  logic strobe;
  logic xfer;
  logic capture;
  logic final_row;

  assign strobe    = hdr_in[STROBE_BIT];
  assign xfer      = out_valid_q & out_ready;
  assign capture   = (state_q == S_IDLE) & strobe;
  assign final_row = (idx_q == LAST_IDX);
  assign idx_d     = idx_q + IDX_ONE;

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;

`ifdef HITMAP_SERIALIZER_HITCOUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [9:0]       fiber_q;
  logic [WIDTH-1:0] trailer_d;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] w);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum = sum + CNT_W'(w[i]);
    end
    return sum;
  endfunction

  // Running hit count including the row currently on the output, and the
  // trailer word built from it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    trailer_d        = '0;
    cnt_d            = cnt_q + popcount(row_q[idx_q]);
    trailer_d[37]    = 1'b1;
    trailer_d[36:26] = 11'b100_0000_0000;
    trailer_d[25:16] = fiber_q;
    trailer_d[10:0]  = cnt_d;
  end
`endif

  // Frame storage, loaded only when a frame is accepted in IDLE.
  // NOTE: the row store is plain data with no reset; it is always fully
  // written at capture before anything reads it, so resetting it buys nothing.
  always_ff @(posedge clk) begin
    if (!rst && capture) begin
      for (int k = 0; k < ROWS; k++) begin
        row_q[k] <= rows_in[WIDTH*k +: WIDTH];
      end
`ifdef HITMAP_SERIALIZER_HITCOUNT_EN
      fiber_q <= hdr_in[25:16];
`endif
    end
  end

  // Frame sequencer with registered stream outputs and overflow tracking.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      idx_q       <= '0;
`ifdef HITMAP_SERIALIZER_HITCOUNT_EN
      cnt_q       <= '0;
`endif
    end else begin
      // A new frame while one is held, even on its final transfer, is lost.
      if (state_q != S_IDLE && strobe) begin
        overflow_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (strobe) begin
            state_q     <= S_HDR;
            out_data_q  <= hdr_in;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b1;
            idx_q       <= '0;
`ifdef HITMAP_SERIALIZER_HITCOUNT_EN
            cnt_q       <= '0;
`endif
          end
        end

        S_HDR: begin
          if (xfer) begin
            state_q    <= S_ROWS;
            idx_q      <= '0;
            out_data_q <= row_q[0];
            out_last_q <= ROW_ENDS_FRAME & (LAST_IDX == '0);
          end
        end

        S_ROWS: begin
          if (xfer) begin
`ifdef HITMAP_SERIALIZER_HITCOUNT_EN
            cnt_q <= cnt_d;
`endif
            if (final_row) begin
`ifdef HITMAP_SERIALIZER_HITCOUNT_EN
              state_q    <= S_TRAIL;
              out_data_q <= trailer_d;
              out_last_q <= 1'b1;
`else
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
`endif
            end else begin
              idx_q      <= idx_d;
              out_data_q <= row_q[idx_d];
              out_last_q <= ROW_ENDS_FRAME & (idx_d == LAST_IDX);
            end
          end
        end

`ifdef HITMAP_SERIALIZER_HITCOUNT_EN
        S_TRAIL: begin
          if (xfer) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
`endif

        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/hitmap_serializer.md
HITMAP_SERIALIZER -- requirements
Module: hitmap_serializer

Interface
REQ-001 Parameter: ROWS, default 38, number of hit-map rows per frame.
REQ-002 Parameter: WIDTH, default 38, bits per row word and per header word.
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: hdr_in  input  WIDTH  frame header from the crate mapper; bit 37 = frame-valid strobe; [25:16] = fiber id.
REQ-006 Port: rows_in  input  ROWS*WIDTH  row k at bits [WIDTH*k+WIDTH-1 : WIDTH*k]; sampled with hdr_in.
REQ-007 Port: out_data  output  WIDTH  serialized word.
REQ-008 Port: out_valid  output  1  out_data holds a valid word.
REQ-009 Port: out_ready  input  1  downstream accepts the word; a transfer occurs when out_valid && out_ready.
REQ-010 Port: out_last  output  1  marks the final word of the frame.
REQ-011 Port: busy  output  1  high while a frame is held (state other than IDLE).
REQ-012 Port: overflow  output  1  sticky flag: a frame was dropped.

Function
REQ-013 States: IDLE, HDR, ROWS (and TRAIL when HITCOUNT_EN is defined).
REQ-014 IDLE: when hdr_in[37]=1 at an edge, capture hdr_in and all rows_in into internal storage and go to HDR; otherwise stay.
REQ-015 Latency: out_valid is 1 with out_data = captured header starting the cycle after capture.
REQ-016 HDR: on transfer, go to ROWS with row index 0.
REQ-017 ROWS: out_data = stored row[index]; on transfer, index increments; transfer of row ROWS-1 ends the frame.
REQ-018 End of frame: go to IDLE; out_valid is 0 in the next cycle.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_last and state are held stable.
REQ-020 out_valid is never deasserted without a transfer, except by reset.
REQ-021 out_last = 1 only on the final word: row ROWS-1, or the trailer when HITCOUNT_EN is defined.
REQ-022 Rows are emitted unmodified, including all-zero rows; a frame is exactly ROWS+1 words (ROWS+2 with HITCOUNT_EN).
REQ-023 hdr_in[37]=1 while not IDLE: the frame is dropped and overflow is set. This includes the cycle of the final transfer. Stored data is unaffected.
REQ-024 overflow clears only on reset.
REQ-025 busy = 1 in every state except IDLE.

Reset
REQ-026 On reset, the state goes to IDLE and out_valid, out_last, busy and overflow go to 0.
REQ-027 On reset, out_data, the row index and the hit counter go to 0.
REQ-028 Reset mid-frame abandons the frame; no further words are emitted; hdr_in is ignored in the reset cycle.

Configuration
REQ-029 Macro HITMAP_SERIALIZER_HITCOUNT_EN defined: a trailer word follows row ROWS-1:
- bit37 = 1
- [36:26] = 11'b10000000000
- [25:16] = captured fiber id
- [15:11] = 0
- [10:0] = total set bits across all stored rows, accumulated one row per cycle as rows are transferred
REQ-030 With the macro defined, out_last moves to the trailer.
REQ-031 Macro undefined: no trailer and no counter logic.

Verification
REQ-032 Capture and order: hdr_in = {1, 0x0400 in [36:26], fiber 0x015 in [25:16], 0xAAAA in [15:0]}, row k = k+1, out_ready=1 -> header next cycle, then rows 1..38 on consecutive cycles; out_last on value 38; busy falls after.
REQ-033 Backpressure: out_ready toggles 1,0,0,1 during rows -> each word held while stalled; no loss or duplication; 39 transfers total.
REQ-034 Overflow: second hdr_in[37] pulse 19 cycles after the first, with out_ready=1 -> second frame dropped; overflow=1; first frame complete and intact.
REQ-035 Reset mid-frame: rst at row 10 -> out_valid=0 and busy=0 the next cycle; a new frame afterwards starts with its header word.
REQ-036 With HITCOUNT_EN: row 0 = all ones (38 bits), row 37 = bit 5 only, others 0 -> trailer [10:0] = 39, [25:16] = fiber id, out_last on trailer.
REQ-037 Boundary: hdr_in[37] in the same cycle as the final transfer -> dropped, overflow=1, state IDLE next cycle.
